pe_os_dbuf: RTL and testbench

Parametrised output-stationary processing element with double-buffered accumulators and configurable input and output register stages. It is the successor to the fixed-width, single-register-stage PE harness in the CPA-F mesh. It forwards `a` horizontally and `b` vertically, multiplies and accumulates into one accumulator bank, and drains/preloads the other bank through the `d`→`c` chain. Bank roles swap when `propagate` toggles, and the shift-with-rounding is applied on that drain.

---
 rtl/pe_cpaf_pkg.sv | 32 +++
 rtl/pe_pipe_reg.sv | 32 +++
 rtl/pe_os_dbuf.sv | 125 ++++++++++++
 tb/tb_pe_os_dbuf.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_cpaf_pkg.sv
// Shared constants and helpers for the CPA-F processing elements.
// round_shift works on a 64-bit container and wraps at the caller's width.
package pe_cpaf_pkg;

    localparam int A_W_DEF     = 8;
    localparam int B_W_DEF     = 8;
    localparam int C_W_DEF     = 32;
    localparam int SHIFT_W_DEF = 6;
    localparam int unsigned MAX_W = 64;

    // Round-half-up arithmetic right shift of a cw-bit value held sign-extended in x.
    function automatic logic signed [MAX_W-1:0] round_shift(
        input logic signed [MAX_W-1:0] x,
        input int unsigned             s,
        input int unsigned             cw
    );
        int unsigned sc;
        int unsigned ext;
        logic signed [MAX_W-1:0] r;
        sc  = (s >= cw) ? cw - 1 : s;
        ext = MAX_W - cw;
        if (sc == 0) begin
            r = x;
        end else begin
            r = x + (64'sd1 <<< (sc - 1));
            r = (r <<< ext) >>> ext;
            r = r >>> sc;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_pipe_reg.sv
// Parametrised delay line; DEPTH of 0 degenerates to a wire.
// All stages clear asynchronously on RST.
module pe_pipe_reg #(
    parameter int DEPTH = 1,
    parameter int W     = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign q = d;
        end else begin : g_regs
            logic [W-1:0] stg [DEPTH];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
                end else begin
                    stg[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
                end
            end

            assign q = stg[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/pe_os_dbuf.sv
// Output-stationary PE with double-buffered accumulators.
// One bank accumulates a*b while the other drains/preloads via d->c.
module pe_os_dbuf
    import pe_cpaf_pkg::*;
#(
    parameter int A_W      = A_W_DEF,
    parameter int B_W      = B_W_DEF,
    parameter int C_W      = C_W_DEF,
    parameter int SHIFT_W  = SHIFT_W_DEF,
    parameter int IN_REGS  = 1,
    parameter int OUT_REGS = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [A_W-1:0]     io_in_a,
    input  logic [B_W-1:0]     io_in_b,
    input  logic [C_W-1:0]     io_in_d,
    input  logic               io_in_valid,
    input  logic [SHIFT_W-1:0] io_in_control_shift,
    input  logic               io_in_control_propagate,
    output logic [A_W-1:0]     io_out_a,
    output logic [B_W-1:0]     io_out_b,
    output logic [C_W-1:0]     io_out_c,
    output logic               io_out_valid,
    output logic [SHIFT_W-1:0] io_out_control_shift,
    output logic               io_out_control_propagate
);

    localparam int BW = A_W + B_W + C_W + SHIFT_W + 2;

    logic [BW-1:0] in_bus;
    logic [BW-1:0] core_bus;
    logic [BW-1:0] res_bus;
    logic [BW-1:0] out_bus;

    logic signed [A_W-1:0] s_a;
    logic signed [B_W-1:0] s_b;
    logic [C_W-1:0]        s_d;
    logic                  s_valid;
    logic [SHIFT_W-1:0]    s_shift;
    logic                  s_prop;

    logic [A_W-1:0]     r_a;
    logic [B_W-1:0]     r_b;
    logic [C_W-1:0]     r_c;
    logic               r_valid;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_prop;

    logic signed [C_W-1:0] acc [2];
    logic                  last_prop;

    logic signed [A_W+B_W-1:0] prod;
    logic signed [C_W-1:0]     sel_acc;
    logic signed [C_W-1:0]     oth_acc;
    logic signed [C_W-1:0]     acc_sum;
    logic signed [C_W-1:0]     c_next;
    logic signed [MAX_W-1:0]   sel_wide;
    logic                      flip;

    assign in_bus = {io_in_a, io_in_b, io_in_d, io_in_valid,
                     io_in_control_shift, io_in_control_propagate};

    pe_pipe_reg #(.DEPTH(IN_REGS), .W(BW)) u_in_pipe (
        .CLK (CLK),
        .RST (RST),
        .d   (in_bus),
        .q   (core_bus)
    );

    assign {s_a, s_b, s_d, s_valid, s_shift, s_prop} = core_bus;

    // P selects the draining bank; the other one accumulates.
    always_comb begin
        sel_acc  = s_prop ? acc[1] : acc[0];
        oth_acc  = s_prop ? acc[0] : acc[1];
        flip     = s_valid & (s_prop != last_prop);
        prod     = s_a * s_b;
        acc_sum  = oth_acc + C_W'(prod);
        sel_wide = MAX_W'(sel_acc);
        c_next   = sel_acc;
        if (flip) begin
            c_next = C_W'(round_shift(sel_wide, 32'(s_shift), C_W));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc[0]    <= '0;
            acc[1]    <= '0;
            last_prop <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_valid   <= 1'b0;
            r_shift   <= '0;
            r_prop    <= 1'b0;
        end else begin
            r_a     <= s_a;
            r_b     <= s_b;
            r_valid <= s_valid;
            r_shift <= s_shift;
            r_prop  <= s_prop;
            if (s_valid) begin
                r_c             <= c_next;
                last_prop       <= s_prop;
                acc[s_prop]     <= s_d;
                acc[~s_prop]    <= acc_sum;
            end
        end
    end

    assign res_bus = {r_a, r_b, r_c, r_valid, r_shift, r_prop};

    pe_pipe_reg #(.DEPTH(OUT_REGS), .W(BW)) u_out_pipe (
        .CLK (CLK),
        .RST (RST),
        .d   (res_bus),
        .q   (out_bus)
    );

    assign {io_out_a, io_out_b, io_out_c, io_out_valid,
            io_out_control_shift, io_out_control_propagate} = out_bus;

endmodule

// File: tb/tb_pe_os_dbuf.sv
// Bench for pe_os_dbuf: four configurations driven in parallel,
// directed scenarios plus a random stream against a reference model.
module tb_pe_os_dbuf;

    localparam int HN = 4096;
    localparam int LAT [4] = '{3, 3, 1, 5};

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        longint     c32;
        longint     c16;
        logic       v;
        logic [5:0] sh;
        logic       p;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [31:0] in_d = '0;
    logic        in_v = 1'b0;
    logic [5:0]  in_sh = '0;
    logic        in_p = 1'b0;

    logic [7:0]  oa [4];
    logic [7:0]  ob [4];
    logic        ov [4];
    logic [5:0]  os [4];
    logic        op [4];
    logic [31:0] oc0, oc2, oc3;
    logic [15:0] oc1;
    longint      obs_c [4];

    int nchk = 0;
    int nerr = 0;

    exp_t   hist [HN];
    int     ncyc = -1;
    int     last_rst = -1;
    longint macc [2][2];
    int     mlast [2];
    longint mc [2];

    always #5 CLK = ~CLK;

    assign obs_c[0] = longint'($signed(oc0));
    assign obs_c[1] = longint'($signed(oc1));
    assign obs_c[2] = longint'($signed(oc2));
    assign obs_c[3] = longint'($signed(oc3));

    pe_os_dbuf dut_def (
        .CLK(CLK), .RST(RST),
        .io_in_a(in_a), .io_in_b(in_b), .io_in_d(in_d), .io_in_valid(in_v),
        .io_in_control_shift(in_sh), .io_in_control_propagate(in_p),
        .io_out_a(oa[0]), .io_out_b(ob[0]), .io_out_c(oc0), .io_out_valid(ov[0]),
        .io_out_control_shift(os[0]), .io_out_control_propagate(op[0])
    );

    pe_os_dbuf #(.C_W(16)) dut_c16 (
        .CLK(CLK), .RST(RST),
        .io_in_a(in_a), .io_in_b(in_b), .io_in_d(in_d[15:0]), .io_in_valid(in_v),
        .io_in_control_shift(in_sh), .io_in_control_propagate(in_p),
        .io_out_a(oa[1]), .io_out_b(ob[1]), .io_out_c(oc1), .io_out_valid(ov[1]),
        .io_out_control_shift(os[1]), .io_out_control_propagate(op[1])
    );

    pe_os_dbuf #(.IN_REGS(0), .OUT_REGS(0)) dut_r0 (
        .CLK(CLK), .RST(RST),
        .io_in_a(in_a), .io_in_b(in_b), .io_in_d(in_d), .io_in_valid(in_v),
        .io_in_control_shift(in_sh), .io_in_control_propagate(in_p),
        .io_out_a(oa[2]), .io_out_b(ob[2]), .io_out_c(oc2), .io_out_valid(ov[2]),
        .io_out_control_shift(os[2]), .io_out_control_propagate(op[2])
    );

    pe_os_dbuf #(.IN_REGS(2), .OUT_REGS(2)) dut_r2 (
        .CLK(CLK), .RST(RST),
        .io_in_a(in_a), .io_in_b(in_b), .io_in_d(in_d), .io_in_valid(in_v),
        .io_in_control_shift(in_sh), .io_in_control_propagate(in_p),
        .io_out_a(oa[3]), .io_out_b(ob[3]), .io_out_c(oc3), .io_out_valid(ov[3]),
        .io_out_control_shift(os[3]), .io_out_control_propagate(op[3])
    );

    function automatic longint wrapw(longint x, int cw);
        longint span;
        longint y;
        span = longint'(1) << cw;
        y = x & (span - 1);
        if (y >= span / 2) y = y - span;
        return y;
    endfunction

    function automatic longint rnd(longint x, int s, int cw);
        int sc;
        sc = (s > cw - 1) ? cw - 1 : s;
        if (sc == 0) return x;
        return wrapw(x + (longint'(1) <<< (sc - 1)), cw) >>> sc;
    endfunction

    // Reference: one valid op per edge, result leaves the PE L cycles later.
    task automatic model_step();
        exp_t e;
        ncyc++;
        e = '0;
        if (RST) begin
            for (int w = 0; w < 2; w++) begin
                macc[w][0] = 0;
                macc[w][1] = 0;
                mlast[w] = 0;
                mc[w] = 0;
            end
            last_rst = ncyc;
        end else begin
            for (int w = 0; w < 2; w++) begin
                int cw;
                int pp;
                cw = (w == 0) ? 32 : 16;
                pp = int'(in_p);
                if (in_v) begin
                    if (pp != mlast[w]) mc[w] = rnd(macc[w][pp], int'(in_sh), cw);
                    else mc[w] = macc[w][pp];
                    macc[w][pp] = wrapw(longint'($signed(in_d)), cw);
                    macc[w][1-pp] = wrapw(macc[w][1-pp] +
                        longint'($signed(in_a)) * longint'($signed(in_b)), cw);
                    mlast[w] = pp;
                end
            end
            e.a = in_a;
            e.b = in_b;
            e.c32 = mc[0];
            e.c16 = mc[1];
            e.v = in_v;
            e.sh = in_sh;
            e.p = in_p;
        end
        if (ncyc < HN) hist[ncyc] = e;
    endtask

    function automatic exp_t expd(int k);
        int m;
        exp_t e;
        m = ncyc - (LAT[k] - 1);
        e = '0;
        if (m > last_rst && m >= 0 && m < HN) e = hist[m];
        return e;
    endfunction

    task automatic tick(input int a, input int b, input longint d,
                        input int v, input int sh, input int p, input int r);
        in_a = 8'(a);
        in_b = 8'(b);
        in_d = 32'(d);
        in_v = 1'(v);
        in_sh = 6'(sh);
        in_p = 1'(p);
        RST = 1'(r);
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        repeat (5) begin
            tick($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1);
            for (int k = 0; k < 4; k++) begin
                nchk++;
                if ({oa[k], ob[k], ov[k], os[k], op[k]} !== '0 || obs_c[k] != 0) begin
                    nerr++;
                    $display("FAIL reset_zero dut%0d: a=%0h b=%0h c=%0d v=%0b", k, oa[k], ob[k], obs_c[k], ov[k]);
                end
            end
        end
        tick($urandom, $urandom, $urandom, 0, $urandom, $urandom, 0);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) continue;
            nchk++;
            if ({oa[k], ob[k], ov[k], os[k], op[k]} !== '0 || obs_c[k] != 0) begin
                nerr++;
                $display("FAIL post_reset_zero dut%0d: a=%0h c=%0d", k, oa[k], obs_c[k]);
            end
        end
        tick(1, 1, 0, 1, 0, 0, 0);
        nchk++;
        if (ov[0] !== 1'b0) begin nerr++; $display("FAIL first_valid_t1: got %0b want 0", ov[0]); end
        tick(0, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (ov[0] !== 1'b0) begin nerr++; $display("FAIL first_valid_t2: got %0b want 0", ov[0]); end
        tick(0, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (ov[0] !== 1'b1) begin nerr++; $display("FAIL first_valid_t3: got %0b want 1", ov[0]); end
        nchk++;
        if (ov[3] !== 1'b0) begin nerr++; $display("FAIL first_valid_l5: got %0b want 0", ov[3]); end
    endtask

    task automatic test_acc_drain();
        tick(0, 0, 0, 0, 0, 0, 1);
        repeat (4) tick(3, -2, 0, 1, 0, 0, 0);
        tick(0, 0, 5, 1, 0, 1, 0);
        nchk++;
        if (obs_c[2] != -24 || ov[2] !== 1'b1) begin
            nerr++; $display("FAIL drain_l1: got c=%0d v=%0b want -24 1", obs_c[2], ov[2]);
        end
        repeat (2) tick(0, 0, 0, 0, 0, 1, 0);
        nchk++;
        if (obs_c[0] != -24 || ov[0] !== 1'b1) begin
            nerr++; $display("FAIL drain_l3: got c=%0d v=%0b want -24 1", obs_c[0], ov[0]);
        end
        nchk++;
        if (obs_c[1] != -24) begin nerr++; $display("FAIL drain_c16: got %0d want -24", obs_c[1]); end
        repeat (2) tick(0, 0, 0, 0, 0, 1, 0);
        nchk++;
        if (obs_c[3] != -24 || ov[3] !== 1'b1) begin
            nerr++; $display("FAIL drain_l5: got c=%0d v=%0b want -24 1", obs_c[3], ov[3]);
        end
        tick(0, 0, 0, 1, 0, 1, 0);
        nchk++;
        if (obs_c[2] != 5) begin nerr++; $display("FAIL preload_5: got %0d want 5", obs_c[2]); end
    endtask

    task automatic test_rounding();
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(11, 2, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 2, 1, 0);
        nchk++;
        if (obs_c[2] != 6) begin nerr++; $display("FAIL round_pos: got %0d want 6", obs_c[2]); end
        tick(-11, 2, 0, 1, 0, 1, 0);
        tick(0, 0, 0, 1, 2, 0, 0);
        nchk++;
        if (obs_c[2] != -5) begin nerr++; $display("FAIL round_neg: got %0d want -5", obs_c[2]); end
        nchk++;
        if (obs_c[0] != 6 || obs_c[1] != 6) begin
            nerr++; $display("FAIL round_pos_l3: got %0d/%0d want 6", obs_c[0], obs_c[1]);
        end
        tick(1, 1, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 63, 1, 0);
        nchk++;
        if (obs_c[2] != 0) begin nerr++; $display("FAIL round_clamp: got %0d want 0", obs_c[2]); end
        nchk++;
        if (obs_c[0] != -5 || obs_c[1] != -5) begin
            nerr++; $display("FAIL round_neg_l3: got %0d/%0d want -5", obs_c[0], obs_c[1]);
        end
        repeat (2) tick(0, 0, 0, 0, 0, 1, 0);
        nchk++;
        if (obs_c[1] != 0) begin nerr++; $display("FAIL round_clamp_c16: got %0d want 0", obs_c[1]); end
    endtask

    task automatic test_wrap();
        tick(0, 0, 0, 0, 0, 0, 1);
        repeat (3) tick(-128, -128, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 1, 0);
        nchk++;
        if (obs_c[2] != 49152) begin nerr++; $display("FAIL nowrap_32: got %0d want 49152", obs_c[2]); end
        repeat (2) tick(0, 0, 0, 0, 0, 1, 0);
        nchk++;
        if (obs_c[1] != -16384) begin nerr++; $display("FAIL wrap_16: got %0d want -16384", obs_c[1]); end
    endtask

    task automatic test_bubble();
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 77, 1, 0, 0, 0);
        tick(2, 5, 0, 1, 0, 0, 0);
        nchk++;
        if (obs_c[2] != 77) begin nerr++; $display("FAIL bub_pre: got %0d want 77", obs_c[2]); end
        tick(7, 9, 0, 0, 0, 1, 0);
        nchk++;
        if (ov[2] !== 1'b0 || obs_c[2] != 77 || oa[2] !== 8'd7 || ob[2] !== 8'd9 || op[2] !== 1'b1) begin
            nerr++;
            $display("FAIL bub_hold: got v=%0b c=%0d a=%0d b=%0d p=%0b want 0 77 7 9 1", ov[2], obs_c[2], oa[2], ob[2], op[2]);
        end
        tick(1, 1, 40, 1, 1, 1, 0);
        nchk++;
        if (obs_c[2] != 5) begin nerr++; $display("FAIL bub_flip: got %0d want 5", obs_c[2]); end
        tick(0, 0, 0, 0, 0, 0, 0);
        nchk++;
        if (ov[0] !== 1'b0 || obs_c[0] != 77 || oa[0] !== 8'd7 || ob[0] !== 8'd9) begin
            nerr++; $display("FAIL bub_l3: got v=%0b c=%0d a=%0d b=%0d want 0 77 7 9", ov[0], obs_c[0], oa[0], ob[0]);
        end
        tick(0, 0, 0, 1, 1, 1, 0);
        nchk++;
        if (obs_c[2] != 40) begin nerr++; $display("FAIL bub_noflip: got %0d want 40", obs_c[2]); end
    endtask

    task automatic test_mid_reset();
        tick(0, 0, 0, 0, 0, 0, 1);
        repeat (3) tick(4, 4, 9, 1, 0, 0, 0);
        tick(4, 4, 9, 1, 0, 0, 1);
        for (int k = 0; k < 4; k++) begin
            nchk++;
            if (ov[k] !== 1'b0 || obs_c[k] != 0 || oa[k] !== 8'd0) begin
                nerr++; $display("FAIL midrst_clear dut%0d: got v=%0b c=%0d a=%0d", k, ov[k], obs_c[k], oa[k]);
            end
        end
        tick(0, 0, 0, 1, 0, 1, 0);
        nchk++;
        if (obs_c[2] != 0 || ov[2] !== 1'b1) begin
            nerr++; $display("FAIL midrst_acc: got c=%0d v=%0b want 0 1", obs_c[2], ov[2]);
        end
        tick(0, 0, 0, 0, 0, 1, 0);
        nchk++;
        if (ov[0] !== 1'b0) begin nerr++; $display("FAIL midrst_inflight: got %0b want 0", ov[0]); end
        tick(0, 0, 0, 0, 0, 1, 0);
        nchk++;
        if (ov[0] !== 1'b1 || obs_c[0] != 0) begin
            nerr++; $display("FAIL midrst_first: got v=%0b c=%0d want 1 0", ov[0], obs_c[0]);
        end
    endtask

    task automatic test_latency();
        int seen [4];
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(8'h5a, 3, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) seen[k] = (ov[k] === 1'b1) ? 0 : -1;
        for (int j = 1; j < 8; j++) begin
            tick(0, 0, 0, 0, 0, 0, 0);
            for (int k = 0; k < 4; k++)
                if (seen[k] < 0 && ov[k] === 1'b1 && oa[k] === 8'h5a) seen[k] = j;
        end
        for (int k = 0; k < 4; k++) begin
            nchk++;
            if (seen[k] + 1 != LAT[k]) begin
                nerr++; $display("FAIL latency dut%0d: got %0d want %0d", k, seen[k] + 1, LAT[k]);
            end
        end
    endtask

    task automatic test_random();
        int p;
        p = 0;
        tick(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) begin
            int sh;
            if ($urandom_range(0, 4) == 0) p = 1 - p;
            sh = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
            tick($urandom, $urandom, longint'($urandom),
                 ($urandom_range(0, 3) != 0) ? 1 : 0, sh, p, 0);
            for (int k = 0; k < 4; k++) begin
                exp_t e;
                longint ec;
                e = expd(k);
                ec = (k == 1) ? e.c16 : e.c32;
                nchk++;
                if (oa[k] !== e.a || ob[k] !== e.b || ov[k] !== e.v || os[k] !== e.sh || op[k] !== e.p) begin
                    nerr++;
                    $display("FAIL rand_fwd dut%0d cyc%0d: got a=%0h b=%0h v=%0b s=%0d p=%0b want %0h %0h %0b %0d %0b",
                             k, i, oa[k], ob[k], ov[k], os[k], op[k], e.a, e.b, e.v, e.sh, e.p);
                end
                nchk++;
                if (obs_c[k] != ec) begin
                    nerr++; $display("FAIL rand_c dut%0d cyc%0d: got %0d want %0d", k, i, obs_c[k], ec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_acc_drain();
        test_rounding();
        test_wrap();
        test_bubble();
        test_mid_reset();
        test_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
